// File: rtl/axi_rd_burst_split.sv
// AXI4 read burst splitter: cuts INCR bursts into sub-bursts of at most MAX_BURST_LEN beats
// and merges R back into one burst per request. Define AXI_RD_SPLIT_4K_EN to also cut at 4KB.
//
// state | meaning
// IDLE  | waiting for an upstream AR; ready while the tracker has room
// ISSUE | presenting sub-bursts downstream until the last chunk is accepted
module axi_rd_burst_split #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int ID_WIDTH      = 8,
    parameter int MAX_BURST_LEN = 16,
    parameter int TRACK_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int PTR_W = (TRACK_DEPTH > 1) ? $clog2(TRACK_DEPTH) : 1;
    localparam int CNT_W = $clog2(TRACK_DEPTH + 1);
    localparam logic [8:0] MAX_LEN = 9'(MAX_BURST_LEN);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(TRACK_DEPTH);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t state, state_nxt;

    logic [8:0]             remaining;
    logic [8:0]             chunk;
    logic [8:0]             nxt_remaining;
    logic [ADDR_WIDTH-1:0]  nxt_addr;
    logic [8:0]             rem_s;
    logic [8:0]             lim_s;
    logic [8:0]             lim_m;
    logic [8:0]             len_s;
    logic [8:0]             len_m;
    logic                   chunk_last;
    logic                   ar_hs_s;
    logic                   push;
    logic                   pop;

    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [TRACK_DEPTH-1:0] last_mem;
    logic                   trk_full;
    logic                   trk_empty;

    function automatic logic [8:0] calc_chunk(input logic [8:0] rem, input logic [1:0] burst,
                                              input logic [8:0] lim);
        if (burst == 2'b01 && rem > lim)
            return lim;
        return rem;
    endfunction

`ifdef AXI_RD_SPLIT_4K_EN
    function automatic logic [8:0] len_limit(input logic [11:0] page_off, input logic [2:0] size);
        logic [12:0] b4k;
        b4k = (13'd4096 - {1'b0, page_off}) >> size;
        // an unaligned start inside the final beat of the page still needs one beat
        if (b4k == 13'd0)
            b4k = 13'd1;
        if (b4k < {4'd0, MAX_LEN})
            return b4k[8:0];
        return MAX_LEN;
    endfunction

    assign lim_s = len_limit(s_axi_araddr[11:0], s_axi_arsize);
    assign lim_m = len_limit(nxt_addr[11:0], m_axi_arsize);
`else
    assign lim_s = MAX_LEN;
    assign lim_m = MAX_LEN;
`endif

    assign rem_s         = {1'b0, s_axi_arlen} + 9'd1;
    assign chunk         = {1'b0, m_axi_arlen} + 9'd1;
    assign chunk_last    = (remaining == chunk);
    assign nxt_remaining = remaining - chunk;
    assign nxt_addr      = (m_axi_araddr & ({ADDR_WIDTH{1'b1}} << m_axi_arsize))
                         + (ADDR_WIDTH'(chunk) << m_axi_arsize);
    assign len_s         = calc_chunk(rem_s, s_axi_arburst, lim_s) - 9'd1;
    assign len_m         = calc_chunk(nxt_remaining, m_axi_arburst, lim_m) - 9'd1;

    assign trk_full  = (count == DEPTH_CNT);
    assign trk_empty = (count == '0);
    assign ar_hs_s   = s_axi_arvalid & s_axi_arready;
    assign push      = m_axi_arvalid & m_axi_arready;
    assign pop       = m_axi_rvalid & s_axi_rready & m_axi_rlast & ~trk_empty;

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        s_axi_arready = 1'b0;
        m_axi_arvalid = 1'b0;
        case (state)
            IDLE: begin
                s_axi_arready = rst & ~trk_full;
                if (s_axi_arvalid & rst & ~trk_full)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                m_axi_arvalid = rst & ~trk_full;
                if (rst & ~trk_full & m_axi_arready & chunk_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The AR field registers double as the working address/attributes of the request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_axi_arid    <= '0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_arsize  <= '0;
            m_axi_arburst <= '0;
            remaining     <= '0;
        end else if (ar_hs_s) begin
            m_axi_arid    <= s_axi_arid;
            m_axi_araddr  <= s_axi_araddr;
            m_axi_arlen   <= len_s[7:0];
            m_axi_arsize  <= s_axi_arsize;
            m_axi_arburst <= s_axi_arburst;
            remaining     <= rem_s;
        end else if (push && !chunk_last) begin
            m_axi_araddr  <= nxt_addr;
            m_axi_arlen   <= len_m[7:0];
            remaining     <= nxt_remaining;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_mem <= '0;
        end else begin
            if (push) begin
                last_mem[wr_ptr] <= chunk_last;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
        end
    end

    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rvalid = m_axi_rvalid;
    assign m_axi_rready = s_axi_rready;
    assign s_axi_rlast  = m_axi_rlast & ~trk_empty & last_mem[rd_ptr];

endmodule

// File: tb/tb_axi_rd_burst_split.sv
// Directed self-checking bench for axi_rd_burst_split with a simple downstream AR/R driver.
module tb_axi_rd_burst_split;

    logic        clk;
    logic        rst;
    logic [7:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [7:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [7:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [7:0]  m_axi_rid;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int ar_n   = 0;
    logic [31:0] ar_addr  [64];
    logic [7:0]  ar_len   [64];
    logic [1:0]  ar_burst [64];
    int          ar_cyc   [64];

    axi_rd_burst_split dut (
        .clk(clk), .rst(rst),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && m_axi_arvalid && m_axi_arready && ar_n < 64) begin
            ar_addr[ar_n]  <= m_axi_araddr;
            ar_len[ar_n]   <= m_axi_arlen;
            ar_burst[ar_n] <= m_axi_arburst;
            ar_cyc[ar_n]   <= cyc;
            ar_n           <= ar_n + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, output int hs);
        int n;
        @(negedge clk);
        s_axi_arid    = 8'h3C;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!s_axi_arready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            total++;
            $display("FAIL ar_accept: s_axi_arready stayed %0b, expected 1", s_axi_arready);
        end
        @(posedge clk);
        hs = cyc;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_ars(input int target);
        int n;
        n = 0;
        while (ar_n < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ar_n < target) begin
            total++;
            $display("FAIL ar_wait: got %0d ARs, expected %0d", ar_n, target);
        end
    endtask

    task automatic send_r(input int nsub, input int sub_len, output int rl_cnt, output int rl_pos,
                          output int d_err);
        int beat;
        rl_cnt = 0;
        rl_pos = 0;
        d_err  = 0;
        beat   = 0;
        for (int s = 0; s < nsub; s++) begin
            for (int j = 0; j < sub_len; j++) begin
                @(negedge clk);
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = 32'hA500_0000 + 32'(beat);
                m_axi_rid    = 8'h3C;
                m_axi_rresp  = 2'b00;
                m_axi_rlast  = (j == sub_len - 1);
                #1;
                if (s_axi_rlast) begin
                    rl_cnt++;
                    rl_pos = beat + 1;
                end
                if (s_axi_rdata !== m_axi_rdata || s_axi_rvalid !== 1'b1 || s_axi_rid !== 8'h3C
                    || s_axi_rresp !== 2'b00 || m_axi_rready !== 1'b1)
                    d_err++;
                beat++;
            end
        end
        @(negedge clk);
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (m_axi_arvalid !== 1'b0) $display("FAIL rst_arvalid: got %0b, expected 0", m_axi_arvalid); else passed++;
        total++; if (s_axi_arready !== 1'b0) $display("FAIL rst_arready: got %0b, expected 0", s_axi_arready); else passed++;
        total++; if (m_axi_araddr !== 32'h0) $display("FAIL rst_araddr: got %0h, expected 0", m_axi_araddr); else passed++;
        total++; if (m_axi_arlen !== 8'h0) $display("FAIL rst_arlen: got %0h, expected 0", m_axi_arlen); else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++; if (s_axi_arready !== 1'b1) $display("FAIL idle_arready: got %0b, expected 1", s_axi_arready); else passed++;
    endtask

    task automatic test_incr_split;
        int base, hs, rc, rp, de;
        base = ar_n;
        send_ar(32'h1000, 8'd63, 3'd2, 2'b01, hs);
        wait_ars(base + 4);
        for (int i = 0; i < 4; i++) begin
            total++; if (ar_addr[base+i] !== 32'h1000 + 32'(i * 64)) $display("FAIL split_addr%0d: got %0h, expected %0h", i, ar_addr[base+i], 32'h1000 + 32'(i * 64)); else passed++;
            total++; if (ar_len[base+i] !== 8'd15) $display("FAIL split_len%0d: got %0d, expected 15", i, ar_len[base+i]); else passed++;
        end
        send_r(4, 16, rc, rp, de);
        total++; if (rc !== 1) $display("FAIL split_rlast_cnt: got %0d, expected 1", rc); else passed++;
        total++; if (rp !== 64) $display("FAIL split_rlast_pos: got %0d, expected 64", rp); else passed++;
        total++; if (de !== 0) $display("FAIL r_passthru: got %0d bad beats, expected 0", de); else passed++;
        total++; if (ar_n - base !== 4) $display("FAIL split_ar_cnt: got %0d, expected 4", ar_n - base); else passed++;
    endtask

    task automatic test_single;
        int base, hs, rc, rp, de;
        base = ar_n;
        send_ar(32'h2000, 8'd7, 3'd2, 2'b01, hs);
        wait_ars(base + 1);
        total++; if (ar_addr[base] !== 32'h2000) $display("FAIL single_addr: got %0h, expected 2000", ar_addr[base]); else passed++;
        total++; if (ar_len[base] !== 8'd7) $display("FAIL single_len: got %0d, expected 7", ar_len[base]); else passed++;
        total++; if (ar_cyc[base] - hs !== 1) $display("FAIL single_latency: got %0d, expected 1", ar_cyc[base] - hs); else passed++;
        send_r(1, 8, rc, rp, de);
        total++; if (rp !== 8 || rc !== 1) $display("FAIL single_rlast: got pos %0d cnt %0d, expected pos 8 cnt 1", rp, rc); else passed++;
    endtask

    task automatic test_4k;
        int base, hs, rc, rp, de;
        base = ar_n;
        send_ar(32'h0FF0, 8'd7, 3'd2, 2'b01, hs);
`ifdef AXI_RD_SPLIT_4K_EN
        wait_ars(base + 2);
        total++; if (ar_addr[base] !== 32'h0FF0 || ar_len[base] !== 8'd3) $display("FAIL 4k_first: got %0h len %0d, expected ff0 len 3", ar_addr[base], ar_len[base]); else passed++;
        total++; if (ar_addr[base+1] !== 32'h1000 || ar_len[base+1] !== 8'd3) $display("FAIL 4k_second: got %0h len %0d, expected 1000 len 3", ar_addr[base+1], ar_len[base+1]); else passed++;
        send_r(2, 4, rc, rp, de);
`else
        wait_ars(base + 1);
        total++; if (ar_addr[base] !== 32'h0FF0 || ar_len[base] !== 8'd7) $display("FAIL 4k_single: got %0h len %0d, expected ff0 len 7", ar_addr[base], ar_len[base]); else passed++;
        send_r(1, 8, rc, rp, de);
`endif
        total++; if (rp !== 8 || rc !== 1) $display("FAIL 4k_rlast: got pos %0d cnt %0d, expected pos 8 cnt 1", rp, rc); else passed++;
    endtask

    task automatic test_wrap;
        int base, hs, rc, rp, de;
        base = ar_n;
        send_ar(32'h3000, 8'd31, 3'd2, 2'b10, hs);
        wait_ars(base + 1);
        repeat (3) @(negedge clk);
        total++; if (ar_n - base !== 1) $display("FAIL wrap_ar_cnt: got %0d, expected 1", ar_n - base); else passed++;
        total++; if (ar_len[base] !== 8'd31 || ar_burst[base] !== 2'b10) $display("FAIL wrap_ar: got len %0d burst %0b, expected len 31 burst 10", ar_len[base], ar_burst[base]); else passed++;
        send_r(1, 32, rc, rp, de);
        total++; if (rp !== 32 || rc !== 1) $display("FAIL wrap_rlast: got pos %0d cnt %0d, expected pos 32 cnt 1", rp, rc); else passed++;
    endtask

    task automatic test_back_to_back;
        int base, hs, rc, rp, de, diffs;
        logic [31:0] h_addr;
        logic [7:0]  h_len;
        base = ar_n;
        send_ar(32'h4000, 8'd127, 3'd2, 2'b01, hs);
        wait_ars(base + 4);
        repeat (5) @(negedge clk);
        total++; if (ar_n - base !== 4) $display("FAIL full_ar_cnt: got %0d, expected 4", ar_n - base); else passed++;
        total++; if (m_axi_arvalid !== 1'b0) $display("FAIL full_arvalid: got %0b, expected 0", m_axi_arvalid); else passed++;
        m_axi_arready = 1'b0;
        send_r(1, 16, rc, rp, de);
        total++; if (rc !== 0) $display("FAIL mid_rlast_cnt: got %0d, expected 0", rc); else passed++;
        #1;
        total++; if (m_axi_arvalid !== 1'b1) $display("FAIL fifth_arvalid: got %0b, expected 1", m_axi_arvalid); else passed++;
        total++; if (m_axi_araddr !== 32'h4100 || m_axi_arlen !== 8'd15) $display("FAIL fifth_ar: got %0h len %0d, expected 4100 len 15", m_axi_araddr, m_axi_arlen); else passed++;
        h_addr = m_axi_araddr;
        h_len  = m_axi_arlen;
        diffs  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_axi_araddr !== h_addr || m_axi_arlen !== h_len || m_axi_arvalid !== 1'b1
                || m_axi_arid !== 8'h3C || m_axi_arsize !== 3'd2 || m_axi_arburst !== 2'b01)
                diffs++;
        end
        total++; if (diffs !== 0) $display("FAIL ar_stable: got %0d changed cycles, expected 0", diffs); else passed++;
        m_axi_arready = 1'b1;
        send_r(7, 16, rc, rp, de);
        wait_ars(base + 8);
        total++; if (rc !== 1 || rp !== 112) $display("FAIL long_rlast: got cnt %0d pos %0d, expected cnt 1 pos 112", rc, rp); else passed++;
        total++; if (ar_addr[base+7] !== 32'h41C0 || ar_len[base+7] !== 8'd15) $display("FAIL eighth_ar: got %0h len %0d, expected 41c0 len 15", ar_addr[base+7], ar_len[base+7]); else passed++;
        total++; if (m_axi_arvalid !== 1'b0 || s_axi_arready !== 1'b1) $display("FAIL long_done: got arvalid %0b arready %0b, expected 0 1", m_axi_arvalid, s_axi_arready); else passed++;
    endtask

    task automatic test_reset_mid;
        int base, hs, rc, rp, de;
        base = ar_n;
        send_ar(32'h5000, 8'd63, 3'd2, 2'b01, hs);
        wait_ars(base + 2);
        m_axi_arready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        total++; if (ar_n - base !== 2) $display("FAIL rstmid_ar_cnt: got %0d, expected 2", ar_n - base); else passed++;
        total++; if (m_axi_arvalid !== 1'b0 || s_axi_arready !== 1'b0) $display("FAIL rstmid_valid: got arvalid %0b arready %0b, expected 0 0", m_axi_arvalid, s_axi_arready); else passed++;
        total++; if (m_axi_araddr !== 32'h0) $display("FAIL rstmid_addr: got %0h, expected 0", m_axi_araddr); else passed++;
        rst = 1'b1;
        m_axi_arready = 1'b1;
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b1;
        #1;
        total++; if (s_axi_rlast !== 1'b0 || s_axi_rvalid !== 1'b1) $display("FAIL stray_rlast: got rlast %0b rvalid %0b, expected 0 1", s_axi_rlast, s_axi_rvalid); else passed++;
        @(negedge clk);
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        base = ar_n;
        send_ar(32'h6000, 8'd15, 3'd2, 2'b01, hs);
        wait_ars(base + 1);
        repeat (3) @(negedge clk);
        total++; if (ar_n - base !== 1 || ar_addr[base] !== 32'h6000 || ar_len[base] !== 8'd15) $display("FAIL post_rst_ar: got cnt %0d addr %0h len %0d, expected 1 6000 15", ar_n - base, ar_addr[base], ar_len[base]); else passed++;
        send_r(1, 16, rc, rp, de);
        total++; if (rc !== 1 || rp !== 16) $display("FAIL post_rst_rlast: got cnt %0d pos %0d, expected 1 16", rc, rp); else passed++;
    endtask

    initial begin
        rst           = 1'b0;
        s_axi_arid    = '0;
        s_axi_araddr  = '0;
        s_axi_arlen   = '0;
        s_axi_arsize  = '0;
        s_axi_arburst = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        m_axi_arready = 1'b1;
        m_axi_rid     = '0;
        m_axi_rdata   = '0;
        m_axi_rresp   = '0;
        m_axi_rlast   = 1'b0;
        m_axi_rvalid  = 1'b0;
        test_reset;
        test_incr_split;
        test_single;
        test_4k;
        test_wrap;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axi_rd_burst_split.md
Name: axi_rd_burst_split

Overview:
AXI4 read-channel burst splitter that sits directly upstream of the AR/R FIFO stage. It accepts INCR read bursts of up to 256 beats on its slave side and re-issues them downstream as bursts of at most MAX_BURST_LEN beats. It merges the returned R beats back into one burst per original request by suppressing intermediate rlast. FIXED and WRAP bursts pass through unsplit.

Parameters:
DATA_WIDTH, 32, R data width in bits
ADDR_WIDTH, 32, AR address width in bits
ID_WIDTH, 8, AR/R ID width in bits
MAX_BURST_LEN, 16, max beats per issued sub-burst (power of 2, 1..256)
TRACK_DEPTH, 4, sub-bursts outstanding on R (tracker FIFO depth, power of 2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset (0 = reset)
s_axi_arid  in  ID_WIDTH  upstream AR ID
s_axi_araddr  in  ADDR_WIDTH  upstream start address
s_axi_arlen  in  8  upstream beats-1
s_axi_arsize  in  3  log2 bytes per beat
s_axi_arburst  in  2  burst type
s_axi_arvalid  in  1  upstream AR valid
s_axi_arready  out  1  upstream AR ready
s_axi_rid  out  ID_WIDTH  R ID to upstream
s_axi_rdata  out  DATA_WIDTH  R data to upstream
s_axi_rresp  out  2  R response to upstream
s_axi_rlast  out  1  merged last beat of original burst
s_axi_rvalid  out  1  R valid to upstream
s_axi_rready  in  1  R ready from upstream
m_axi_arid  out  ID_WIDTH  sub-burst ID (= original ID)
m_axi_araddr  out  ADDR_WIDTH  sub-burst address
m_axi_arlen  out  8  sub-burst beats-1
m_axi_arsize  out  3  copied arsize
m_axi_arburst  out  2  copied arburst
m_axi_arvalid  out  1  sub-burst valid
m_axi_arready  in  1  downstream AR ready
m_axi_rid  in  ID_WIDTH  downstream R ID
m_axi_rdata  in  DATA_WIDTH  downstream R data
m_axi_rresp  in  2  downstream R response
m_axi_rlast  in  1  downstream sub-burst last
m_axi_rvalid  in  1  downstream R valid
m_axi_rready  out  1  R ready to downstream

Behaviour:
- Reset (rst=0 at clk edge): FSM to IDLE, tracker emptied, m_axi_arvalid=0, s_axi_arready=0; all m_axi_ar* field registers 0. Reset mid-burst drops all captured and outstanding state; no completion is generated.
- FSM IDLE: s_axi_arready=1 iff tracker not full. On AR handshake: capture id, addr, remaining=arlen+1 (9 bits), size, burst; go to ISSUE. m_axi_arvalid rises the cycle after the handshake (1-cycle AR latency).
- ISSUE: chunk = remaining for FIXED/WRAP/reserved; for INCR chunk = min(remaining, MAX_BURST_LEN, beats_to_4k). beats_to_4k = (4096 - addr[11:0]) >> size. m_axi_arlen = chunk-1. m_axi_arvalid asserted only while tracker not full.
- On m_axi_ar handshake: push flag last=(remaining==chunk) into tracker. Then addr = (addr & ~((1<<size)-1)) + (chunk<<size) and remaining -= chunk. If last, go to IDLE; else stay in ISSUE. Next sub-burst valid no earlier than the following cycle.
- m_axi_ar* are registered and held stable while arvalid=1 and arready=0.
- R path is combinational pass-through: rid, rdata, rresp, rvalid forward to s_axi_*; m_axi_rready = s_axi_rready. s_axi_rlast = m_axi_rlast & tracker_head.last.
- Tracker pops on m_axi_rvalid & m_axi_rready & m_axi_rlast. Full/empty are based on the current count; a push while full is blocked even if a pop occurs in the same cycle. Push and pop in the same non-full cycle keep the count unchanged.
- R beat arriving with tracker empty is forwarded with s_axi_rlast=0 (protocol violation by downstream).
- R return order must match AR issue order; IDs are not used for tracking.

Optional Feature:
AXI_RD_SPLIT_4K_EN: when defined, INCR sub-bursts are also cut at 4KB boundaries using beats_to_4k. When undefined, beats_to_4k is ignored; upstream guarantees no 4KB crossing and split is by length only.

Test Plan:
- INCR arlen=63 addr 0x1000 size 2, MAX=16 -> 4 ARs at 0x1000/0x1040/0x1080/0x10C0, len 15 each; 64 R beats; s_axi_rlast only on beat 64.
- INCR arlen=7 addr 0x2000 -> single AR addr 0x2000 len 7, m_axi_arvalid one cycle after s handshake; s_axi_rlast on beat 8.
- INCR addr 0x0FF0 arlen 7 size 2 with AXI_RD_SPLIT_4K_EN -> ARs 0x0FF0 len 3 and 0x1000 len 3; without macro -> one AR 0x0FF0 len 7.
- WRAP arlen 31 -> one AR len 31, burst 2'b10 unchanged; rlast passes on beat 32.
- TRACK_DEPTH 4, INCR arlen 127, no R returned -> exactly 4 ARs issued then arvalid low. After one R sub-burst completes, the 5th AR issues. m_axi_arready held 0 for 10 cycles keeps all ar fields stable.
- rst=0 during ISSUE after 2 of 4 sub-bursts -> next cycle arvalid=0, arready=0, tracker empty. After rst=1, a new arlen=15 request issues a single AR.
